// File: rtl/network_seq_pkg.sv
// Shared types and helpers for the sequenced stochastic network: sequencer
// state encoding, config-map offsets, LFSR tap masks and output scaling.
package network_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEED = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } seq_state_e;

  // Config map is row-major: w1[h][i], b1[h], w2[o][h], b2[o].
  function automatic int w1_base();
    return 0;
  endfunction

  function automatic int b1_base(input int i_sz, input int h_sz);
    return w1_base() + h_sz * i_sz;
  endfunction

  function automatic int w2_base(input int i_sz, input int h_sz);
    return b1_base(i_sz, h_sz) + h_sz;
  endfunction

  function automatic int b2_base(input int i_sz, input int h_sz, input int o_sz);
    return w2_base(i_sz, h_sz) + o_sz * h_sz;
  endfunction

  function automatic int cfg_depth(input int i_sz, input int h_sz, input int o_sz);
    return b2_base(i_sz, h_sz, o_sz) + o_sz;
  endfunction

  // Right-shifting Galois masks giving a maximal-length sequence (period 2^w-1).
  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0E08;
      13:      return 32'h0000_1C80;
      14:      return 32'h0000_3802;
      15:      return 32'h0000_6000;
      default: return 32'h0000_B400;
    endcase
  endfunction

  // Scale a ones-count down to the data width; a full window clamps to max
  // instead of wrapping to zero.
  function automatic logic [31:0] sat_shift(input logic [31:0] cnt, input int sh, input int dw);
    logic [31:0] v;
    logic [31:0] mx;
    v  = cnt >> sh;
    mx = (32'd1 << dw) - 32'd1;
    return (v > mx) ? mx : v;
  endfunction

endpackage

// File: rtl/network_sequencer.sv
// Evaluation sequencer: input/output handshakes, one-cycle reseed pulse,
// fixed-length run window with a warm-up region that is not counted.
module network_sequencer
  import network_seq_pkg::*;
#(
  parameter int STREAM_LEN = 256,
  parameter int PIPE_LAT   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic out_ready,
  output logic in_ready,
  output logic accept,
  output logic out_valid,
  output logic busy,
  output logic seed_pulse,
  output logic count_en,
  output logic last_cnt
);

  localparam int RUN_LEN = PIPE_LAT + STREAM_LEN;
  localparam int CNTW    = $clog2(RUN_LEN);

  seq_state_e      state_q;
  logic [CNTW-1:0] cnt_q;
  logic            seed_pulse_q;

  // in_ready is held low for as long as rst is asserted.
  assign in_ready   = (state_q == S_IDLE) && !rst;
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q == S_SEED) || (state_q == S_RUN);
  assign seed_pulse = seed_pulse_q;
  assign count_en   = (state_q == S_RUN) && (cnt_q >= CNTW'(PIPE_LAT));
  assign last_cnt   = (state_q == S_RUN) && (cnt_q == CNTW'(RUN_LEN - 1));

  // State machine, run-window counter and glitch-free reseed pulse.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      seed_pulse_q <= 1'b0;
    end else begin
      seed_pulse_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q      <= S_SEED;
            seed_pulse_q <= 1'b1;
          end
        end
        S_SEED: begin
          state_q <= S_RUN;
          cnt_q   <= '0;
        end
        S_RUN: begin
          if (last_cnt) state_q <= S_DONE;
          else          cnt_q   <= cnt_q + CNTW'(1);
        end
        S_DONE: begin
          if (out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/network_sequenced.sv
// Input -> hidden -> output stochastic network with a loadable weight/bias
// file. Each value v becomes a bitstream (lfsr <= v); multiply is AND and
// neuron accumulation is OR. Results are ones-counts over a fixed window.
module network_sequenced
  import network_seq_pkg::*;
#(
  parameter int INPUT_SIZE  = 2,
  parameter int HIDDEN_SIZE = 2,
  parameter int OUTPUT_SIZE = 1,
  parameter int DATA_WIDTH  = 8,
  parameter int STREAM_LEN  = 256,
  parameter int PIPE_LAT    = 2,
  parameter int SEED        = 25,
  parameter int CFG_DEPTH   = cfg_depth(INPUT_SIZE, HIDDEN_SIZE, OUTPUT_SIZE),
  parameter int CFG_AW      = $clog2(CFG_DEPTH)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cfg_we,
  input  logic [CFG_AW-1:0]                 cfg_addr,
  input  logic [DATA_WIDTH-1:0]             cfg_wdata,
  output logic                              cfg_ack,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [INPUT_SIZE*DATA_WIDTH-1:0]  in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [OUTPUT_SIZE*DATA_WIDTH-1:0] out_data,
  output logic                              busy
);

  localparam int LOG_SL = $clog2(STREAM_LEN);
  localparam int CW     = LOG_SL + 1;
  localparam int SHIFT  = LOG_SL - DATA_WIDTH;
  localparam int W1_B   = w1_base();
  localparam int B1_B   = b1_base(INPUT_SIZE, HIDDEN_SIZE);
  localparam int W2_B   = w2_base(INPUT_SIZE, HIDDEN_SIZE);
  localparam int B2_B   = b2_base(INPUT_SIZE, HIDDEN_SIZE, OUTPUT_SIZE);
  localparam logic [DATA_WIDTH-1:0] TAPS = DATA_WIDTH'(lfsr_taps(DATA_WIDTH));

  logic accept, seed_pulse, count_en, last_cnt, sub_rst_n, cfg_hit;

  logic [DATA_WIDTH-1:0]             cfg_q [CFG_DEPTH];
  logic [INPUT_SIZE*DATA_WIDTH-1:0]  in_q;
  logic [DATA_WIDTH-1:0]             in_lfsr_q [INPUT_SIZE];
  logic [DATA_WIDTH-1:0]             l1_lfsr_q, l2_lfsr_q;
  logic [INPUT_SIZE-1:0]             x_bit;
  logic [HIDDEN_SIZE-1:0]            hid_d, hid_q;
  logic [OUTPUT_SIZE-1:0]            out_d, out_bit_q;
  logic [CW-1:0]                     ones_q [OUTPUT_SIZE];
  logic [OUTPUT_SIZE*DATA_WIDTH-1:0] out_data_q;
  logic                              cfg_ack_q;

  network_sequencer #(
    .STREAM_LEN(STREAM_LEN),
    .PIPE_LAT  (PIPE_LAT)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .accept    (accept),
    .out_valid (out_valid),
    .busy      (busy),
    .seed_pulse(seed_pulse),
    .count_en  (count_en),
    .last_cnt  (last_cnt)
  );

  // Datapath state restarts from its seeds on every reseed pulse.
  assign sub_rst_n = !(rst | seed_pulse);
  assign cfg_hit   = cfg_we && in_ready && (int'(cfg_addr) < CFG_DEPTH);
  assign cfg_ack   = cfg_ack_q;
  assign out_data  = out_data_q;

  function automatic logic [DATA_WIDTH-1:0] lfsr_next(input logic [DATA_WIDTH-1:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  // Config file, input latch, write acknowledge and result register.
  // NOTE: the weight file is reset explicitly because a cleared network is
  // the documented post-reset behaviour; storage without that need stays unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < CFG_DEPTH; k++) cfg_q[k] <= '0;
      in_q       <= '0;
      cfg_ack_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      cfg_ack_q <= cfg_hit;
      for (int k = 0; k < CFG_DEPTH; k++)
        if (cfg_hit && (cfg_addr == CFG_AW'(k))) cfg_q[k] <= cfg_wdata;
      if (accept) in_q <= in_data;
      if (last_cnt)
        for (int o = 0; o < OUTPUT_SIZE; o++)
          out_data_q[o*DATA_WIDTH +: DATA_WIDTH] <= DATA_WIDTH'(sat_shift(
            32'(ones_q[o]) + 32'(out_bit_q[o]), SHIFT, DATA_WIDTH));
    end
  end

  // Bitstream generation and both neuron layers, combinationally.
  // NOTE: every output gets a default at the top so no path can infer a latch.
  always_comb begin
    x_bit = '0;
    hid_d = '0;
    out_d = '0;
    for (int i = 0; i < INPUT_SIZE; i++)
      x_bit[i] = (in_lfsr_q[i] <= in_q[i*DATA_WIDTH +: DATA_WIDTH]);
    for (int h = 0; h < HIDDEN_SIZE; h++) begin
      hid_d[h] = (l1_lfsr_q <= cfg_q[B1_B+h]);
      for (int i = 0; i < INPUT_SIZE; i++)
        hid_d[h] = hid_d[h] | (x_bit[i] & (l1_lfsr_q <= cfg_q[W1_B+h*INPUT_SIZE+i]));
    end
    for (int o = 0; o < OUTPUT_SIZE; o++) begin
      out_d[o] = (l2_lfsr_q <= cfg_q[B2_B+o]);
      for (int h = 0; h < HIDDEN_SIZE; h++)
        out_d[o] = out_d[o] | (hid_q[h] & (l2_lfsr_q <= cfg_q[W2_B+o*HIDDEN_SIZE+h]));
    end
  end

  // Generators, layer registers and ones-counters, all reseeded per evaluation.
  always_ff @(posedge clk or negedge sub_rst_n) begin
    if (!sub_rst_n) begin
      for (int i = 0; i < INPUT_SIZE; i++) in_lfsr_q[i] <= DATA_WIDTH'(SEED + 5 * i);
      l1_lfsr_q <= DATA_WIDTH'(SEED);
      l2_lfsr_q <= DATA_WIDTH'(SEED);
      hid_q     <= '0;
      out_bit_q <= '0;
      for (int o = 0; o < OUTPUT_SIZE; o++) ones_q[o] <= '0;
    end else begin
      for (int i = 0; i < INPUT_SIZE; i++) in_lfsr_q[i] <= lfsr_next(in_lfsr_q[i]);
      l1_lfsr_q <= lfsr_next(l1_lfsr_q);
      l2_lfsr_q <= lfsr_next(l2_lfsr_q);
      hid_q     <= hid_d;
      out_bit_q <= out_d;
      if (count_en)
        for (int o = 0; o < OUTPUT_SIZE; o++) ones_q[o] <= ones_q[o] + CW'(out_bit_q[o]);
    end
  end

endmodule

// File: tb/tb_network_sequenced.sv
// Directed bench for network_sequenced. Expected results use the fact that a
// maximal 8-bit LFSR visits 1..255 once per 255 steps, so a 256-sample window
// of stream "lfsr <= v" holds v ones plus one repeat of the seed sample.
module tb_network_sequenced;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [7:0]  cfg_wdata;
  logic        cfg_ack, cfg_ack2;
  logic        in_valid, in_valid2;
  logic        in_ready, in_ready2;
  logic [15:0] in_data;
  logic        out_valid, out_valid2;
  logic        out_ready, out_ready2;
  logic [7:0]  out_data, out_data2;
  logic        busy, busy2;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  network_sequenced dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_ack(cfg_ack), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  // Long-window instance: count of 512 shifted right by 1 must clamp to 255.
  network_sequenced #(.STREAM_LEN(512)) dut512 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_ack(cfg_ack2), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [7:0] d, input logic exp_ack,
                           input string tag);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
    check(tag, cfg_ack, exp_ack);
  endtask

  // One evaluation on the default instance. hold>0 keeps out_ready low for
  // that many DONE cycles while offering a new vector; mid_wr attempts a
  // config write in RUN.
  task automatic run_vec(input logic [15:0] din, input int hold, input bit mid_wr,
                         input logic [7:0] exp_out, input string tag,
                         output logic [7:0] got);
    int n;
    bit ack_seen, held_ok;
    out_ready = (hold == 0);
    @(negedge clk);
    in_data = din; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check($sformatf("%s.in_ready_after_accept", tag), in_ready, 1'b0);
    check($sformatf("%s.busy_after_accept", tag), busy, 1'b1);
    n = 1; ack_seen = 1'b0;
    while (out_valid !== 1'b1 && n < 2000) begin
      if (mid_wr && n == 50) begin
        cfg_we = 1'b1; cfg_addr = 4'd1; cfg_wdata = 8'd0;
      end else begin
        cfg_we = 1'b0;
      end
      @(negedge clk);
      n++;
      if (cfg_ack === 1'b1) ack_seen = 1'b1;
    end
    cfg_we = 1'b0;
    check($sformatf("%s.latency", tag), n, 260);
    check($sformatf("%s.out_data", tag), out_data, exp_out);
    got = out_data;
    if (mid_wr) check($sformatf("%s.run_write_acked", tag), ack_seen, 1'b0);
    if (hold > 0) begin
      held_ok = 1'b1;
      in_valid = 1'b1;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        if (out_valid !== 1'b1 || out_data !== exp_out || in_ready !== 1'b0) held_ok = 1'b0;
      end
      check($sformatf("%s.backpressure_hold", tag), held_ok, 1'b1);
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    check($sformatf("%s.out_valid_after_hs", tag), out_valid, 1'b0);
    check($sformatf("%s.in_ready_after_hs", tag), in_ready, 1'b1);
  endtask

  initial begin
    logic [7:0] r0, r1, r2;
    int n2;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    in_valid = 1'b0; in_valid2 = 1'b0; in_data = '0;
    out_ready = 1'b1; out_ready2 = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst.in_ready", in_ready, 1'b0);
    check("rst.out_valid", out_valid, 1'b0);
    check("rst.busy", busy, 1'b0);
    check("rst.cfg_ack", cfg_ack, 1'b0);
    check("rst.out_data", out_data, 8'd0);
    rst = 1'b0;
    #1;
    check("rst.in_ready_first_idle", in_ready, 1'b1);

    // All-zero network, {128,64}: latency and handshake, result 0.
    run_vec({8'd128, 8'd64}, 0, 1'b0, 8'd0, "lat", r0);

    // Config gating in IDLE: ack pulse, one cycle wide; out-of-range ignored.
    cfg_write(4'd0, 8'd213, 1'b1, "cfg.addr0_ack");
    @(negedge clk);
    check("cfg.ack_one_cycle", cfg_ack, 1'b0);
    cfg_write(4'd6, 8'd255, 1'b1, "cfg.w2_ack");
    cfg_write(4'd9, 8'd77, 1'b0, "cfg.addr9_ignored");

    // x0 all ones, hidden0 = w1[0][0] stream (213, seed 25) -> 213 + 1.
    run_vec({8'd0, 8'd255}, 0, 1'b0, 8'd214, "w1", r0);

    // Route only input 1 (200, seed 30) to the output -> 200 + 1.
    cfg_write(4'd0, 8'd0, 1'b1, "cfg.clear_w00");
    cfg_write(4'd1, 8'd255, 1'b1, "cfg.set_w01");
    run_vec({8'd200, 8'd30}, 0, 1'b0, 8'd201, "det1", r1);
    run_vec({8'd200, 8'd30}, 50, 1'b0, 8'd201, "det2", r2);
    check("det.repeatable", r2, r1);

    // Write attempted during RUN is dropped; result matches the plain run.
    run_vec({8'd200, 8'd30}, 0, 1'b1, 8'd201, "runwr", r0);

    // Bias only: b1[0]=100 (seed 25) -> 100 + 1.
    cfg_write(4'd1, 8'd0, 1'b1, "cfg.clear_w01");
    cfg_write(4'd4, 8'd100, 1'b1, "cfg.set_b10");
    run_vec({8'd0, 8'd0}, 0, 1'b0, 8'd101, "bias", r0);

    // Reset at RUN cycle 100 aborts and clears everything.
    @(negedge clk);
    in_data = 16'hFFFF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (101) @(negedge clk);
    check("abort.busy_before", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("abort.busy", busy, 1'b0);
    check("abort.out_valid", out_valid, 1'b0);
    check("abort.out_data", out_data, 8'd0);
    check("abort.in_ready", in_ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort.in_ready_first_idle", in_ready, 1'b1);
    // Weights were cleared, so even all-ones inputs give 0.
    run_vec(16'hFFFF, 0, 1'b0, 8'd0, "post_rst", r0);

    // Saturation: everything 255 -> all-ones stream -> 256 clamps to 255.
    for (int a = 0; a < 9; a++) cfg_write(4'(a), 8'd255, 1'b1, "cfg.sat_ack");
    run_vec(16'hFFFF, 0, 1'b0, 8'd255, "sat256", r0);

    // Same config landed in the 512-window instance while it sat in IDLE.
    @(negedge clk);
    in_valid2 = 1'b1;
    @(negedge clk);
    in_valid2 = 1'b0;
    n2 = 1;
    while (out_valid2 !== 1'b1 && n2 < 2000) begin
      @(negedge clk);
      n2++;
    end
    check("sat512.latency", n2, 516);
    check("sat512.out_data", out_data2, 8'd255);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/network_sequenced.md
Name: network_sequenced

Overview:
- Parametrised successor to the fixed single-layer perceptron network: input -> hidden -> output stochastic network with run-time loadable weights and biases.
- Adds a valid/ready sequencer that reseeds the bitstream generators, runs a fixed-length evaluation window, and presents integrated results.
- Identical inputs and weights always give identical results.
- Sits between the host/testbench data source and downstream consumers; reuses the existing generator and layer blocks internally.

Parameters:
- INPUT_SIZE, 2, number of network inputs
- HIDDEN_SIZE, 2, hidden-layer neuron count
- OUTPUT_SIZE, 1, output neuron count
- DATA_WIDTH, 8, width of inputs, weights, biases and outputs (unsigned; value v means probability v/2^DATA_WIDTH)
- STREAM_LEN, 256, evaluation window in cycles; power of two, at least 2^DATA_WIDTH
- PIPE_LAT, 2, warm-up cycles discarded before counting (generator plus two-layer latency)
- SEED, 25, base LFSR seed; input generator i uses SEED+5*i; layers use SEED

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cfg_we  in  1  config write strobe
- cfg_addr  in  CFG_AW  config word address (CFG_AW = clog2(CFG_DEPTH))
- cfg_wdata  in  DATA_WIDTH  weight/bias value
- cfg_ack  out  1  one-cycle pulse: write accepted
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept an input vector
- in_data  in  INPUT_SIZE*DATA_WIDTH  input vector; element i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  OUTPUT_SIZE*DATA_WIDTH  result vector, same packing as in_data
- busy  out  1  high in SEED and RUN

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - All weights, biases, input latches, counters and out_data are cleared to 0.
  - in_ready=0 while rst is high, then 1 in the first IDLE cycle.
  - out_valid=0, busy=0, cfg_ack=0.
  - rst asserted mid-RUN or mid-DONE aborts the evaluation; the partial result is lost.
- Config map, row-major:
  - [0, H*I): w1[h][i]
  - [H*I, H*I+H): b1[h]
  - next O*H words: w2[o][h]
  - next O words: b2[o]
  - CFG_DEPTH = H*I + H + O*H + O.
- Config writes:
  - Accepted only in IDLE with cfg_addr < CFG_DEPTH. The register updates on that edge and cfg_ack pulses the next cycle.
  - Writes in any other state, or to an out-of-range address, are ignored with no cfg_ack.
  - If cfg_we and an in_valid accept coincide in IDLE, both take effect; the new weight applies to that evaluation.
- FSM states: IDLE, SEED, RUN, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_data and go to SEED.
  - SEED: exactly one cycle. Synchronously reset all generator LFSRs to their seeds, reset layer state, clear the ones-counters and the cycle counter. Go to RUN.
  - RUN: lasts PIPE_LAT+STREAM_LEN cycles.
    - Cycle counter runs 0..PIPE_LAT+STREAM_LEN-1.
    - Output ones-counters increment on cycles where counter >= PIPE_LAT and the output bit is 1.
    - At the last count, load out_data and go to DONE.
  - DONE: out_valid=1, out_data stable. When out_valid&out_ready, go to IDLE; in_ready rises the following cycle.
- Output arithmetic:
  - Counters are clog2(STREAM_LEN)+1 bits wide.
  - out_data[o] = count[o] >> (clog2(STREAM_LEN)-DATA_WIDTH), saturated to 2^DATA_WIDTH-1 (an all-ones stream gives the max value, never wraps to 0).
- Latency: accept edge t0 -> out_valid high in cycle t0+2+PIPE_LAT+STREAM_LEN (260 cycles at defaults).
- Throughput: one vector per STREAM_LEN+PIPE_LAT+3 cycles when out_ready is held high.
- in_valid while not IDLE is ignored; no queueing.
- Sub-blocks that use active-low reset are driven with !(rst | seed_pulse).

Decomposition:
- network_seq_pkg: state enum (IDLE/SEED/RUN/DONE), CFG offset functions (w1_base, b1_base, w2_base, b2_base, cfg_depth), and the saturating shift function.
- Sub-module network_sequencer: FSM, cycle counter, in/out handshakes, seed_pulse and count_en outputs.
- The top level holds the config register file, generator instances, two layer instances and the ones-counters.

Test Plan:
- Reset mid-RUN: accept vector, assert rst at RUN cycle 100 -> busy=0, out_valid=0 and out_data=0 immediately; in_ready=1 first cycle after rst drops; a weight read-back via new evaluation with all cfg=0 matches the post-reset golden value.
- Latency and handshake:
  - in_data={128,64}, defaults, out_ready=1 -> out_valid exactly 260 cycles after accept, 1 cycle wide; in_ready low from accept until the cycle after the out handshake.
  - Backpressure: out_ready=0 for 50 cycles in DONE -> out_valid and out_data held constant, no new input accepted.
- Determinism: same cfg and in_data={200,30} run twice -> identical out_data, both matching the bit-accurate golden model.
- Config gating:
  - Write addr 0 = 213 in IDLE -> cfg_ack next cycle.
  - Write during RUN -> no cfg_ack, result unchanged versus a run without the write.
  - Write to addr CFG_DEPTH (9) -> ignored.
- Saturation: force a constant-1 output stream (inputs 255, all weights and biases 255, with the golden model confirming all ones) -> out_data=255, not 0; with STREAM_LEN=512 the shift is 1 and the result is still 255.
